// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: EX operand forwarding, load-use bubble and load-miss freeze with timeout watchdog.
// Optional build macro FWD_STATS_EN adds saturating stall/freeze/forward event counters.

// Per-source operand mux: EX/MEM > MEM/WB > history (newest first) > register file.
module fwd_src_sel #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int HD_W   = 1
) (
    input  logic [REG_AW-1:0]            rs,
    input  logic [XLEN-1:0]              rf_opnd,
    input  logic [REG_AW-1:0]            mem_rd,
    input  logic                         mem_regwrite,
    input  logic                         mem_memread,
    input  logic [XLEN-1:0]              mem_data,
    input  logic [REG_AW-1:0]            wb_rd,
    input  logic                         wb_regwrite,
    input  logic [XLEN-1:0]              wb_data,
    input  logic [HD_W-1:0]              hist_valid,
    input  logic [HD_W-1:0][REG_AW-1:0]  hist_rd,
    input  logic [HD_W-1:0][XLEN-1:0]    hist_data,
    output logic [1:0]                   sel,
    output logic [XLEN-1:0]              opnd
);

    always_comb begin
        sel  = 2'b00;
        opnd = rf_opnd;
        if (rs != '0) begin
            if (mem_regwrite && !mem_memread && (mem_rd == rs)) begin
                sel  = 2'b10;
                opnd = mem_data;
            end else if (wb_regwrite && (wb_rd == rs)) begin
                sel  = 2'b01;
                opnd = wb_data;
            end else begin
                // Walk oldest to newest so the newest match wins.
                for (int i = HD_W - 1; i >= 0; i--) begin
                    if (hist_valid[i] && (hist_rd[i] == rs)) begin
                        sel  = 2'b11;
                        opnd = hist_data[i];
                    end
                end
            end
        end
    end

endmodule

module fwd_hazard_unit #(
    parameter int XLEN       = 32,
    parameter int REG_AW     = 5,
    parameter int NUM_SRC    = 2,
    parameter int HIST_DEPTH = 1,
    parameter int TIMEOUT    = 64
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      id_valid_i,
    input  logic [NUM_SRC*REG_AW-1:0] id_rs_i,
    input  logic [NUM_SRC*REG_AW-1:0] ex_rs_i,
    input  logic [NUM_SRC*XLEN-1:0]   ex_opnd_i,
    input  logic [REG_AW-1:0]         ex_rd_i,
    input  logic                      ex_memread_i,
    input  logic [REG_AW-1:0]         mem_rd_i,
    input  logic                      mem_regwrite_i,
    input  logic                      mem_memread_i,
    input  logic [XLEN-1:0]           mem_data_i,
    input  logic                      dmem_ready_i,
    input  logic [REG_AW-1:0]         wb_rd_i,
    input  logic                      wb_regwrite_i,
    input  logic [XLEN-1:0]           wb_data_i,
    output logic [NUM_SRC*XLEN-1:0]   ex_opnd_o,
    output logic [NUM_SRC*2-1:0]      fwd_sel_o,
    output logic                      stall_o,
    output logic                      flush_ex_o,
    output logic                      freeze_o,
    output logic                      timeout_o
`ifdef FWD_STATS_EN
    ,
    output logic [31:0]               stat_stall_o,
    output logic [31:0]               stat_freeze_o,
    output logic [31:0]               stat_fwd_o
`endif
);

    localparam int HD_W = (HIST_DEPTH > 0) ? HIST_DEPTH : 1;
    localparam int CW   = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_RUN, S_WAIT, S_TMO} state_t;

    state_t                      state;
    logic [CW-1:0]               cnt;
    logic                        freeze;
    logic                        lu_match;
    logic                        load_use;
    logic [HD_W-1:0]             hist_valid;
    logic [HD_W-1:0][REG_AW-1:0] hist_rd;
    logic [HD_W-1:0][XLEN-1:0]   hist_data;
    logic [NUM_SRC-1:0][1:0]     sel_raw;
    logic [NUM_SRC-1:0][XLEN-1:0] opnd_raw;

    // ---------------- operand selection ----------------
    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        fwd_src_sel #(
            .XLEN   (XLEN),
            .REG_AW (REG_AW),
            .HD_W   (HD_W)
        ) u_sel (
            .rs           (ex_rs_i[k*REG_AW +: REG_AW]),
            .rf_opnd      (ex_opnd_i[k*XLEN +: XLEN]),
            .mem_rd       (mem_rd_i),
            .mem_regwrite (mem_regwrite_i),
            .mem_memread  (mem_memread_i),
            .mem_data     (mem_data_i),
            .wb_rd        (wb_rd_i),
            .wb_regwrite  (wb_regwrite_i),
            .wb_data      (wb_data_i),
            .hist_valid   (hist_valid),
            .hist_rd      (hist_rd),
            .hist_data    (hist_data),
            .sel          (sel_raw[k]),
            .opnd         (opnd_raw[k])
        );
    end

    assign fwd_sel_o = rst_i ? '0 : sel_raw;
    assign ex_opnd_o = rst_i ? '0 : opnd_raw;

    // ---------------- write-back history ----------------
    if (HIST_DEPTH > 0) begin : g_hist
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                hist_valid <= '0;
                hist_rd    <= '0;
                hist_data  <= '0;
            end else if (wb_regwrite_i && (wb_rd_i != '0) && !freeze) begin
                for (int i = HIST_DEPTH - 1; i > 0; i--) begin
                    hist_valid[i] <= hist_valid[i-1];
                    hist_rd[i]    <= hist_rd[i-1];
                    hist_data[i]  <= hist_data[i-1];
                end
                hist_valid[0] <= 1'b1;
                hist_rd[0]    <= wb_rd_i;
                hist_data[0]  <= wb_data_i;
            end
        end
    end else begin : g_no_hist
        assign hist_valid = '0;
        assign hist_rd    = '0;
        assign hist_data  = '0;
    end

    // ---------------- load-use and freeze ----------------
    always_comb begin
        lu_match = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (id_rs_i[k*REG_AW +: REG_AW] == ex_rd_i) lu_match = 1'b1;
        end
    end

    assign load_use = id_valid_i && ex_memread_i && (ex_rd_i != '0) && lu_match;

    // Once timed out the freeze is dropped so the core can reach its error handling.
    assign freeze = ((state == S_RUN) || (state == S_WAIT)) && mem_memread_i && !dmem_ready_i;

    assign freeze_o   = !rst_i && freeze;
    assign stall_o    = !rst_i && (freeze || load_use);
    assign flush_ex_o = !rst_i && !freeze && load_use;

    // ---------------- load wait FSM ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= S_RUN;
            cnt       <= '0;
            timeout_o <= 1'b0;
        end else begin
            case (state)
                S_RUN: begin
                    if (mem_memread_i && !dmem_ready_i) begin
                        state <= S_WAIT;
                        cnt   <= CW'(1);
                    end
                end
                S_WAIT: begin
                    if (dmem_ready_i) begin
                        state <= S_RUN;
                        cnt   <= '0;
                    end else if (cnt == CW'(TIMEOUT)) begin
                        state     <= S_TMO;
                        timeout_o <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_TMO: timeout_o <= 1'b1;
                default: begin
                    state <= S_RUN;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef FWD_STATS_EN
    // ---------------- saturating event counters ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stat_stall_o  <= '0;
            stat_freeze_o <= '0;
            stat_fwd_o    <= '0;
        end else begin
            if (flush_ex_o && (stat_stall_o != '1))     stat_stall_o  <= stat_stall_o + 32'd1;
            if (freeze_o && (stat_freeze_o != '1))      stat_freeze_o <= stat_freeze_o + 32'd1;
            if ((|fwd_sel_o) && (stat_fwd_o != '1))     stat_fwd_o    <= stat_fwd_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed vector table, hand-written multi-cycle sequences,
// and randomized traffic compared every cycle against a queue-based reference model.
module tb_fwd_hazard_unit;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NS   = 2;
    localparam int HD   = 1;
    localparam int TMO  = 8;

    logic clk = 1'b0;
    logic rst;
    logic id_valid;
    logic [NS*AW-1:0]   id_rs, ex_rs;
    logic [NS*XLEN-1:0] ex_opnd;
    logic [AW-1:0]      ex_rd, mem_rd, wb_rd;
    logic ex_mr, mem_rw, mem_mr, ready, wb_rw;
    logic [XLEN-1:0]    mem_data, wb_data;
    logic [NS*XLEN-1:0] opnd_o;
    logic [NS*2-1:0]    sel_o;
    logic stall_o, flush_o, freeze_o, timeout_o;

    always #5 clk = ~clk;

    fwd_hazard_unit #(.XLEN(XLEN), .REG_AW(AW), .NUM_SRC(NS), .HIST_DEPTH(HD), .TIMEOUT(TMO)) dut (
        .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rs_i(id_rs), .ex_rs_i(ex_rs),
        .ex_opnd_i(ex_opnd), .ex_rd_i(ex_rd), .ex_memread_i(ex_mr), .mem_rd_i(mem_rd),
        .mem_regwrite_i(mem_rw), .mem_memread_i(mem_mr), .mem_data_i(mem_data),
        .dmem_ready_i(ready), .wb_rd_i(wb_rd), .wb_regwrite_i(wb_rw), .wb_data_i(wb_data),
        .ex_opnd_o(opnd_o), .fwd_sel_o(sel_o), .stall_o(stall_o), .flush_ex_o(flush_o),
        .freeze_o(freeze_o), .timeout_o(timeout_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { logic [AW-1:0] rd; logic [XLEN-1:0] data; } hent_t;
    hent_t hq[$];      // retired write-backs, newest at index 0
    int    m_wait;     // cycles spent waiting on the current load, 0 = not waiting
    bit    m_tmo;

    function automatic void model_clear();
        hq.delete();
        m_wait = 0;
        m_tmo  = 0;
    endfunction

    function automatic bit m_freeze();
        return !rst && !m_tmo && mem_mr && !ready;
    endfunction

    function automatic bit m_loaduse();
        bit hit = 0;
        for (int k = 0; k < NS; k++) if (id_rs[k*AW +: AW] == ex_rd) hit = 1;
        return !rst && id_valid && ex_mr && ex_rd != 0 && hit;
    endfunction

    function automatic void m_fwd(input logic [AW-1:0] rs, input logic [XLEN-1:0] rf,
                                  output logic [1:0] sel, output logic [XLEN-1:0] d);
        sel = 2'b00;
        d   = rf;
        if (rst) begin d = '0; return; end
        if (rs == 0) return;
        if (mem_rw && !mem_mr && mem_rd == rs) begin sel = 2'b10; d = mem_data; return; end
        if (wb_rw && wb_rd == rs)              begin sel = 2'b01; d = wb_data;  return; end
        foreach (hq[i]) if (hq[i].rd == rs) begin sel = 2'b11; d = hq[i].data; return; end
    endfunction

    task automatic model_cmp(input string tag);
        logic [NS*2-1:0]    e_sel;
        logic [NS*XLEN-1:0] e_opnd;
        logic [1:0]         s;
        logic [XLEN-1:0]    d;
        bit fz, lu;
        for (int k = 0; k < NS; k++) begin
            m_fwd(ex_rs[k*AW +: AW], ex_opnd[k*XLEN +: XLEN], s, d);
            e_sel[k*2 +: 2]     = s;
            e_opnd[k*XLEN +: XLEN] = d;
        end
        fz = m_freeze();
        lu = m_loaduse();
        chk({tag, ".sel"},     sel_o,     e_sel);
        chk({tag, ".opnd"},    opnd_o,    e_opnd);
        chk({tag, ".stall"},   stall_o,   fz || lu);
        chk({tag, ".flush"},   flush_o,   !fz && lu);
        chk({tag, ".freeze"},  freeze_o,  fz);
        chk({tag, ".timeout"}, timeout_o, m_tmo);
    endtask

    function automatic void model_update();
        hent_t e;
        if (rst) begin model_clear(); return; end
        if (wb_rw && wb_rd != 0 && !m_freeze()) begin
            e.rd = wb_rd; e.data = wb_data;
            hq.push_front(e);
            if (hq.size() > HD) void'(hq.pop_back());
        end
        if (m_tmo) return;
        if (m_wait > 0) begin
            if (ready)              m_wait = 0;
            else if (m_wait == TMO) m_tmo  = 1;
            else                    m_wait++;
        end else if (mem_mr && !ready) begin
            m_wait = 1;
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic settle();
        #4;
    endtask

    task automatic adv(input string tag);
        model_cmp(tag);
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        id_valid = 0; id_rs = '0; ex_rs = '0; ex_opnd = {32'hBBBB0001, 32'hAAAA0000};
        ex_rd = 0; ex_mr = 0; mem_rd = 0; mem_rw = 0; mem_mr = 0; mem_data = 0;
        ready = 1; wb_rd = 0; wb_rw = 0; wb_data = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        model_clear();
        settle();
        adv("rst");
        rst = 0;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [NS*AW-1:0] ex_rs;
        logic [AW-1:0]    mem_rd;  logic mem_rw, mem_mr; logic [XLEN-1:0] mem_data;
        logic [AW-1:0]    wb_rd;   logic wb_rw;          logic [XLEN-1:0] wb_data;
        logic             id_valid; logic [NS*AW-1:0] id_rs; logic [AW-1:0] ex_rd; logic ex_mr;
        logic [NS*2-1:0]  e_sel;   logic [NS*XLEN-1:0] e_opnd; logic e_stall, e_flush;
    } vec_t;

    vec_t tv[$];
    vec_t v;

    initial begin
        clr_inputs();
        rst = 1;
        model_clear();

        // Reset state with busy inputs: everything must read zero.
        ex_rs = 10'h005; mem_rd = 5; mem_rw = 1; mem_data = 32'h11; mem_mr = 1; ready = 0;
        id_valid = 1; id_rs = 10'h003; ex_rd = 3; ex_mr = 1;
        settle();
        chk("reset.sel", sel_o, 0);
        chk("reset.opnd", opnd_o, 0);
        chk("reset.stall", stall_o, 0);
        chk("reset.flush", flush_o, 0);
        chk("reset.freeze", freeze_o, 0);
        chk("reset.timeout", timeout_o, 0);
        adv("reset");
        clr_inputs();
        rst = 0;

        // EX/MEM beats MEM/WB
        v = '{default:'0}; v.ex_rs = 10'h005; v.mem_rd = 5; v.mem_rw = 1; v.mem_data = 32'h11;
        v.wb_rd = 5; v.wb_rw = 1; v.wb_data = 32'h22;
        v.e_sel = 4'b0010; v.e_opnd = {32'hBBBB0001, 32'h11}; tv.push_back(v);
        // x0 never forwards
        v = '{default:'0}; v.mem_rw = 1; v.mem_data = 32'h11; v.wb_rw = 1; v.wb_data = 32'h22;
        v.e_sel = 4'b0000; v.e_opnd = {32'hBBBB0001, 32'hAAAA0000}; tv.push_back(v);
        // MEM/WB on src1
        v = '{default:'0}; v.ex_rs = 10'h0C0; v.mem_rd = 5; v.mem_rw = 1; v.mem_data = 32'h11;
        v.wb_rd = 6; v.wb_rw = 1; v.wb_data = 32'h33;
        v.e_sel = 4'b0100; v.e_opnd = {32'h33, 32'hAAAA0000}; tv.push_back(v);
        // EX/MEM load result is not forwardable, falls to MEM/WB
        v = '{default:'0}; v.ex_rs = 10'h005; v.mem_rd = 5; v.mem_rw = 1; v.mem_mr = 1; v.mem_data = 32'h11;
        v.wb_rd = 5; v.wb_rw = 1; v.wb_data = 32'h22;
        v.e_sel = 4'b0001; v.e_opnd = {32'hBBBB0001, 32'h22}; tv.push_back(v);
        // both sources from EX/MEM
        v = '{default:'0}; v.ex_rs = 10'h0A5; v.mem_rd = 5; v.mem_rw = 1; v.mem_data = 32'h11;
        v.e_sel = 4'b1010; v.e_opnd = {32'h11, 32'h11}; tv.push_back(v);
        // load-use on id src1
        v = '{default:'0}; v.id_valid = 1; v.id_rs = 10'h060; v.ex_rd = 3; v.ex_mr = 1;
        v.e_opnd = {32'hBBBB0001, 32'hAAAA0000}; v.e_stall = 1; v.e_flush = 1; tv.push_back(v);
        // same, but ID slot invalid
        v = '{default:'0}; v.id_rs = 10'h060; v.ex_rd = 3; v.ex_mr = 1;
        v.e_opnd = {32'hBBBB0001, 32'hAAAA0000}; tv.push_back(v);
        // load to x0 is never a hazard
        v = '{default:'0}; v.id_valid = 1; v.ex_mr = 1;
        v.e_opnd = {32'hBBBB0001, 32'hAAAA0000}; tv.push_back(v);
        // EX/MEM without regwrite is ignored
        v = '{default:'0}; v.ex_rs = 10'h005; v.mem_rd = 5; v.mem_data = 32'h11;
        v.e_opnd = {32'hBBBB0001, 32'hAAAA0000}; tv.push_back(v);

        foreach (tv[i]) begin
            clr_inputs();
            do_reset();
            ex_rs = tv[i].ex_rs; mem_rd = tv[i].mem_rd; mem_rw = tv[i].mem_rw; mem_mr = tv[i].mem_mr;
            mem_data = tv[i].mem_data; wb_rd = tv[i].wb_rd; wb_rw = tv[i].wb_rw; wb_data = tv[i].wb_data;
            id_valid = tv[i].id_valid; id_rs = tv[i].id_rs; ex_rd = tv[i].ex_rd; ex_mr = tv[i].ex_mr;
            settle();
            chk($sformatf("tv%0d.sel", i),   sel_o,   tv[i].e_sel);
            chk($sformatf("tv%0d.opnd", i),  opnd_o,  tv[i].e_opnd);
            chk($sformatf("tv%0d.stall", i), stall_o, tv[i].e_stall);
            chk($sformatf("tv%0d.flush", i), flush_o, tv[i].e_flush);
            adv($sformatf("tv%0d", i));
        end

        // ---- history forwarding, then freeze keeps history still ----
        clr_inputs();
        do_reset();
        wb_rw = 1; wb_rd = 7; wb_data = 32'hAB;
        settle(); adv("hist.wr");
        wb_rw = 0; ex_rs = 10'h0E0;
        settle();
        chk("hist.sel", sel_o, 4'b1100);
        chk("hist.opnd1", opnd_o[63:32], 32'hAB);
        adv("hist.rd");
        mem_mr = 1; ready = 0; wb_rw = 1; wb_rd = 9; wb_data = 32'h55;
        for (int c = 0; c < 4; c++) begin
            settle();
            chk($sformatf("miss%0d.freeze", c), freeze_o, 1);
            chk($sformatf("miss%0d.stall", c), stall_o, 1);
            adv($sformatf("miss%0d", c));
        end
        ready = 1; wb_rw = 0;
        settle();
        chk("miss.done.freeze", freeze_o, 0);
        adv("miss.done");
        mem_mr = 0; ex_rs = 10'h0E9;
        settle();
        chk("miss.hist.sel", sel_o, 4'b1100);
        chk("miss.hist.opnd1", opnd_o[63:32], 32'hAB);
        adv("miss.after");
        mem_mr = 1; ready = 0;
        settle();
        chk("miss.rerun.freeze", freeze_o, 1);
        adv("miss.rerun");

        // ---- one bubble per load ----
        clr_inputs();
        do_reset();
        id_valid = 1; id_rs = 10'h060; ex_rd = 3; ex_mr = 1;
        settle();
        chk("lu.stall", stall_o, 1);
        chk("lu.flush", flush_o, 1);
        adv("lu");
        ex_mr = 0; ex_rd = 0; mem_rd = 3; mem_mr = 1; mem_rw = 1;
        settle();
        chk("lu.after.stall", stall_o, 0);
        chk("lu.after.flush", flush_o, 0);
        adv("lu.after");

        // ---- timeout, freeze beats load-use, reset clears ----
        clr_inputs();
        do_reset();
        mem_mr = 1; ready = 0; mem_rd = 4;
        id_valid = 1; id_rs = 10'h003; ex_rd = 3; ex_mr = 1;
        for (int c = 0; c <= TMO; c++) begin
            settle();
            chk($sformatf("tmo%0d.freeze", c), freeze_o, 1);
            chk($sformatf("tmo%0d.flush", c), flush_o, 0);
            chk($sformatf("tmo%0d.timeout", c), timeout_o, 0);
            adv($sformatf("tmo%0d", c));
        end
        settle();
        chk("tmo.timeout", timeout_o, 1);
        chk("tmo.freeze", freeze_o, 0);
        chk("tmo.flush", flush_o, 1);
        adv("tmo");
        settle();
        chk("tmo.sticky", timeout_o, 1);
        adv("tmo.sticky");
        rst = 1;
        model_clear();
        #1;
        chk("tmo.rst.timeout", timeout_o, 0);
        chk("tmo.rst.stall", stall_o, 0);
        chk("tmo.rst.flush", flush_o, 0);
        chk("tmo.rst.freeze", freeze_o, 0);
        #3;
        adv("tmo.rst");
        rst = 0;

        // ---- reset in the middle of a wait ----
        clr_inputs();
        do_reset();
        mem_mr = 1; ready = 0;
        settle(); adv("mw0");
        settle(); adv("mw1");
        rst = 1;
        model_clear();
        settle();
        chk("mw.rst.freeze", freeze_o, 0);
        adv("mw.rst");
        rst = 0; mem_mr = 0;
        settle();
        chk("mw.after.freeze", freeze_o, 0);
        adv("mw.after");
        mem_mr = 1; ready = 1;
        settle();
        chk("mw.hit.freeze", freeze_o, 0);
        adv("mw.hit");

        // ---- randomized traffic against the model ----
        clr_inputs();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            if (n % 80 == 79) begin
                do_reset();
            end else begin
                for (int k = 0; k < NS; k++) begin
                    ex_rs[k*AW +: AW] = AW'($urandom_range(0, 7));
                    id_rs[k*AW +: AW] = AW'($urandom_range(0, 7));
                end
                ex_opnd  = {$urandom, $urandom};
                id_valid = 1'($urandom_range(0, 1));
                ex_rd    = AW'($urandom_range(0, 7));
                ex_mr    = ($urandom_range(0, 2) == 0);
                mem_rd   = AW'($urandom_range(0, 7));
                mem_rw   = 1'($urandom_range(0, 1));
                mem_mr   = ($urandom_range(0, 2) == 0);
                mem_data = $urandom;
                ready    = ($urandom_range(0, 3) != 0);
                wb_rd    = AW'($urandom_range(0, 7));
                wb_rw    = 1'($urandom_range(0, 1));
                wb_data  = $urandom;
                settle();
                adv($sformatf("rnd%0d", n));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
